// File: rtl/systolic_matmul_engine.sv
// Output-stationary NxN systolic matrix-multiply engine: skewed operand injection, start/done
// job control, valid/ready streaming in and out, and row-serial drain of the accumulators.
module systolic_matmul_engine #(
  parameter int unsigned N     = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned KW    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KW-1:0]          k_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*W-1:0]         a_col,
  input  logic [N*W-1:0]         b_row,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*ACC_W-1:0]     out_row,
  output logic [$clog2(N)-1:0]   out_idx,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned IW = $clog2(N);
  localparam int unsigned FW = $clog2(2 * N);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StFeed  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [KW-1:0] cnt_q, cnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;

  logic step;
  logic clr;

  logic [W-1:0]     a_feed [N];
  logic [W-1:0]     b_feed [N];
  logic [W-1:0]     a_edge [N];
  logic [W-1:0]     b_edge [N];
  logic [W-1:0]     a_pe   [N][N];
  logic [W-1:0]     b_pe   [N][N];
  logic [ACC_W-1:0] acc    [N][N];
  logic [ACC_W-1:0] acc_sum [N][N];

  assign step = ((state_q == StFeed) && in_valid) || (state_q == StFlush);
  assign clr  = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    fcnt_d  = fcnt_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          k_d     = k_len;
          cnt_d   = '0;
          fcnt_d  = '0;
          idx_d   = '0;
          state_d = (|k_len) ? StFeed : StFlush;
        end
      end
      StFeed: begin
        if (in_valid) begin
          if (cnt_q == k_q - KW'(1)) begin
            cnt_d   = '0;
            state_d = StFlush;
          end else begin
            cnt_d = cnt_q + KW'(1);
          end
        end
      end
      StFlush: begin
        // 2N-1 zero steps let the last beat reach and be accumulated in PE(N-1,N-1)
        if (fcnt_q == FW'(2 * N - 2)) begin
          fcnt_d  = '0;
          state_d = StDrain;
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (idx_q == IW'(N - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      cnt_q   <= '0;
      fcnt_q  <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      fcnt_q  <= fcnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_feed[r] = (state_q == StFeed) ? a_col[r*W +: W] : '0;
      b_feed[r] = (state_q == StFeed) ? b_row[r*W +: W] : '0;
    end
  end

  // Lane r of each operand passes through an r-deep chain so beats enter the array diagonally
  for (genvar r = 0; r < N; r++) begin : g_skew
    if (r == 0) begin : g_direct
      assign a_edge[r] = a_feed[r];
      assign b_edge[r] = b_feed[r];
    end else begin : g_chain
      logic [W-1:0] a_q [r];
      logic [W-1:0] b_q [r];
      always_ff @(posedge clock or posedge reset) begin
        if (reset || clr) begin
          for (int j = 0; j < r; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
          end
        end else if (step) begin
          a_q[0] <= a_feed[r];
          b_q[0] <= b_feed[r];
          for (int j = 1; j < r; j++) begin
            a_q[j] <= a_q[j-1];
            b_q[j] <= b_q[j-1];
          end
        end
      end
      assign a_edge[r] = a_q[r-1];
      assign b_edge[r] = b_q[r-1];
    end
  end

  // Operands are sign-extended to ACC_W first; the low ACC_W product bits then wrap correctly
  always_comb begin
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        acc_sum[r][c] = acc[r][c] + ACC_W'($signed(a_pe[r][c])) * ACC_W'($signed(b_pe[r][c]));
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_pe[r][c] <= '0;
          b_pe[r][c] <= '0;
          acc[r][c]  <= '0;
        end
      end
    end else if (clr) begin
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_pe[r][c] <= '0;
          b_pe[r][c] <= '0;
          acc[r][c]  <= '0;
        end
      end
    end else if (step) begin
      for (int r = 0; r < N; r++) begin
        a_pe[r][0] <= a_edge[r];
        b_pe[0][r] <= b_edge[r];
        for (int c = 0; c < N; c++) begin
          acc[r][c] <= acc_sum[r][c];
        end
        for (int c = 1; c < N; c++) begin
          a_pe[r][c] <= a_pe[r][c-1];
          b_pe[c][r] <= b_pe[c-1][r];
        end
      end
    end
  end

  always_comb begin
    out_row = '0;
    if (state_q == StDrain) begin
      for (int r = 0; r < N; r++) begin
        if (IW'(r) == idx_q) begin
          for (int c = 0; c < N; c++) begin
            out_row[c*ACC_W +: ACC_W] = acc[r][c];
          end
        end
      end
    end
  end

  assign in_ready  = (state_q == StFeed);
  assign out_valid = (state_q == StDrain);
  assign out_idx   = idx_q;
  assign busy      = (state_q != StIdle);
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed bench for systolic_matmul_engine (N=4): a plain sum-of-products matrix model is
// checked against every presented result row, with literal pins on the model.
module tb_systolic_matmul_engine;

  localparam int N     = 4;
  localparam int W     = 32;
  localparam int ACC_W = 32;
  localparam int KW    = 16;
  localparam int KMAX  = 8;

  logic               clock = 1'b0;
  logic               reset;
  logic               start;
  logic [KW-1:0]      k_len;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     a_col;
  logic [N*W-1:0]     b_row;
  logic               out_valid;
  logic               out_ready;
  logic [N*ACC_W-1:0] out_row;
  logic [1:0]         out_idx;
  logic               busy;
  logic               done;

  int a_m   [N][KMAX];
  int b_m   [KMAX][N];
  int exp_c [N][N];

  int n_err    = 0;
  int n_chk    = 0;
  int exp_idx  = 0;
  bit hs_last  = 1'b0;
  int done_cnt = 0;

  systolic_matmul_engine #(.N(N), .W(W), .ACC_W(ACC_W), .KW(KW)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_col     (a_col),
    .b_row     (b_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic compute_model(input int k);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        exp_c[i][j] = 0;
        for (int kk = 0; kk < k; kk++) exp_c[i][j] += a_m[i][kk] * b_m[kk][j];
      end
    end
  endtask

  // Per-cycle compare against the model; rows must come out in order 0..N-1 exactly once
  always @(negedge clock) begin
    if (reset) begin
      exp_idx = 0;
      hs_last = 1'b0;
    end else begin
      check("done_pulse", done, hs_last);
      if (done) done_cnt++;
      hs_last = 1'b0;
      check("ready_valid_excl", in_ready & out_valid, 0);
      if (out_valid) begin
        check("out_idx", out_idx, exp_idx);
        for (int c = 0; c < N; c++)
          check($sformatf("row%0d_col%0d", exp_idx, c), out_row[c*ACC_W +: ACC_W],
                exp_c[exp_idx][c]);
        if (out_ready) begin
          hs_last = (exp_idx == N - 1);
          exp_idx = (exp_idx + 1) % N;
        end
      end
    end
  end

  task automatic start_job(input int k);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clock); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("in_ready_after_start", in_ready, (k != 0));
  endtask

  task automatic feed(input int nb, input int mode);
    int bi = 0;
    int t  = 0;
    while (bi < nb && t < 200) begin
      bit v;
      bit acc_now;
      v = (mode == 0) || (t % 3 == 0);
      in_valid = v;
      for (int r = 0; r < N; r++) begin
        a_col[r*W +: W] = v ? a_m[r][bi] : $urandom;
        b_row[r*W +: W] = v ? b_m[bi][r] : $urandom;
      end
      acc_now = v && in_ready;
      @(posedge clock); #1;
      if (acc_now) bi++;
      t++;
    end
    in_valid = 1'b0;
    check("feed_beats", bi, nb);
  endtask

  task automatic drain(input bit stall, input bit poke);
    int guard = 0;
    int st    = 0;
    bit seen  = 1'b0;
    while (!seen && guard < 300) begin
      out_ready = 1'b1;
      if (stall && out_valid && out_idx == 2 && st < 5) begin
        out_ready = 1'b0;
        st++;
      end
      start = poke && out_valid;
      k_len = KW'(5);
      @(posedge clock); #1;
      seen = done;
      guard++;
    end
    start     = 1'b0;
    out_ready = 1'b0;
    check("drain_done_seen", seen, 1);
  endtask

  task automatic finish_job(input int d0);
    @(posedge clock); #1;
    check("done_once", done_cnt - d0, 1);
    check("idle_busy", busy, 0);
    check("idle_in_ready", in_ready, 0);
    check("idle_out_valid", out_valid, 0);
    check("done_one_cycle", done, 0);
  endtask

  task automatic run_job(input int k, input int mode, input bit stall);
    int d0;
    compute_model(k);
    d0 = done_cnt;
    start_job(k);
    feed(k, mode);
    drain(stall, 1'b0);
    finish_job(d0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int cyc;
    reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
    a_col = '0; b_row = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) for (int j = 0; j < N; j++) exp_c[i][j] = 0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_row_or", |out_row, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;

    // T1: identity times B
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_m[i][j] = (i == j) ? 1 : 0;
        b_m[i][j] = 4 * i + j;
      end
    run_job(4, 0, 1'b0);
    check("pin_t1_c23", exp_c[2][3], 11);

    // T2: sparse in_valid cadence
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 4; k++) begin
        a_m[i][k] = i + k;
        b_m[k][i] = k - i;
      end
    run_job(4, 1, 1'b0);
    check("pin_t2_c30", exp_c[3][0], 32);
    check("pin_t2_c12", exp_c[1][2], 0);
    check("pin_t2_c03", exp_c[0][3], 32'hFFFF_FFFC);

    // T3: same job, output back-pressure on row 2
    run_job(4, 0, 1'b1);

    // T4: wraparound and negative operands
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
        a_m[i][k] = 32'h7FFF_FFFF;
        b_m[k][i] = 2;
      end
    run_job(3, 0, 1'b0);
    check("pin_t4_wrap", exp_c[0][0], 32'hFFFF_FFFA);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 3; k++) begin
        a_m[i][k] = -3;
        b_m[k][i] = 5;
      end
    run_job(3, 1, 1'b0);
    check("pin_t4_neg", exp_c[3][1], 32'hFFFF_FFD3);

    // T5: async reset after two of four beats, then a clean k_len=2 job
    d0 = done_cnt;
    compute_model(4);
    start_job(4);
    feed(2, 0);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("abort_no_done", done_cnt - d0, 0);
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 2; k++) begin
        a_m[i][k] = i - 2 * k;
        b_m[k][i] = i + k + 1;
      end
    run_job(2, 0, 1'b0);

    // T6: k_len=0 flushes 2N-1 cycles, drains zeros, ignores start during drain
    compute_model(0);
    d0 = done_cnt;
    start_job(0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("flush_latency", cyc, 2 * N - 1);
    drain(1'b0, 1'b1);
    finish_job(d0);
    repeat (3) @(posedge clock);
    #1;
    check("post_poke_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
